// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding
// and the counter-width helper used by every channel.
package button_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOCK_P = 2'd1,
      ST_HELD   = 2'd2,
      ST_LOCK_R = 2'd3
   } state_t;

   function automatic int unsigned cnt_width(input int unsigned long_cycles,
                                             input int unsigned deb_cycles);
      int unsigned top_v;
      if (long_cycles > deb_cycles) begin
         top_v = long_cycles;
      end else begin
         top_v = deb_cycles;
      end
      return $clog2(top_v + 32'd1);
   endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// One button: polarity fold, 2-flop synchroniser, lockout debounce FSM with a
// saturating timer, and registered level/press/release/long-press outputs.
module button_debounce_channel
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 50_000_000,
   parameter int unsigned ACTIVE_LOW      = 0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic level,
   output logic press,
   output logic release_pulse,
   output logic long_press
);

   localparam int unsigned      CNT_W     = cnt_width(LONG_CYCLES, DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 32'd1);
   // With long-press disabled the timer only needs to outrun the lockout.
   localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'((LONG_CYCLES != 32'd0) ? LONG_CYCLES
                                                                         : DEBOUNCE_CYCLES);
   localparam logic             LONG_EN   = (LONG_CYCLES != 32'd0);
   localparam logic             POL       = (ACTIVE_LOW != 32'd0);

   logic [1:0]       sync_q, sync_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             long_q, long_d;
   logic             act_s;
   logic [CNT_W-1:0] cnt_inc_s;

   assign act_s = sync_q[1];

   // Next-state, timer and output-pulse logic.
   always_comb begin
      sync_d    = {sync_q[0], btn_in ^ POL};
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      if (cnt_q >= CNT_SAT) begin
         cnt_inc_s = cnt_q;
      end else begin
         cnt_inc_s = cnt_q + CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            level_d = 1'b0;
            if (act_s) begin
               state_d = ST_LOCK_P;
               level_d = 1'b1;
               press_d = 1'b1;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCK_P: begin
            cnt_d = cnt_inc_s;
            if (cnt_q == DEB_LAST) begin
               state_d = ST_HELD;
            end else begin
               state_d = ST_LOCK_P;
            end
         end
         ST_HELD: begin
            // A release on the threshold cycle takes priority over long-press.
            if (!act_s) begin
               state_d = ST_LOCK_R;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc_s;
               if (LONG_EN && (cnt_q == LONG_LAST)) begin
                  long_d = 1'b1;
               end else begin
                  long_d = 1'b0;
               end
            end
         end
         ST_LOCK_R: begin
            cnt_d = cnt_inc_s;
            if (cnt_q == DEB_LAST) begin
               state_d   = ST_IDLE;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               state_d = ST_LOCK_R;
            end
         end
         default: begin
            state_d = ST_IDLE;
            level_d = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // State, synchroniser and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= 2'b00;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         long_q    <= long_d;
      end
   end

   assign level         = level_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign long_press    = long_q;

endmodule

// File: rtl/button_debounce_array.sv
// Multi-channel push-button conditioner; each bit of btn_in gets its own
// independent debounce channel.
module button_debounce_array
   import button_pkg::*;
#(
   parameter int unsigned CHANNELS        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned LONG_CYCLES     = 50_000_000,
   parameter int unsigned ACTIVE_LOW      = 0
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] btn_in,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] press,
   output logic [CHANNELS-1:0] release_pulse,
   output logic [CHANNELS-1:0] long_press
);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      button_debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_ch (
         .clk           (clk),
         .reset_n       (reset_n),
         .btn_in        (btn_in[g]),
         .level         (level[g]),
         .press         (press[g]),
         .release_pulse (release_pulse[g]),
         .long_press    (long_press[g])
      );
   end

endmodule

// File: tb/tb_button_debounce_array.sv
// Directed bench: an active-high and an active-low array side by side,
// every cycle compared against hand-derived expected output vectors.
module tb_button_debounce_array;

   logic       clk;
   logic       reset_n;
   logic [1:0] btn, btn_al;
   logic [1:0] lv_m, pr_m, rl_m, lg_m;
   logic [1:0] lv_a, pr_a, rl_a, lg_a;
   int         tests;
   int         fails;

   button_debounce_array #(
      .CHANNELS(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(16), .ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn_in(btn),
      .level(lv_m), .press(pr_m), .release_pulse(rl_m), .long_press(lg_m)
   );

   button_debounce_array #(
      .CHANNELS(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(16), .ACTIVE_LOW(1)
   ) dut_al (
      .clk(clk), .reset_n(reset_n), .btn_in(btn_al),
      .level(lv_a), .press(pr_a), .release_pulse(rl_a), .long_press(lg_a)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vector layout: {level[1:0], press[1:0], release[1:0], long_press[1:0]}
   function automatic logic [7:0] v(input logic [1:0] lv, input logic [1:0] pr,
                                    input logic [1:0] rl, input logic [1:0] lg);
      return {lv, pr, rl, lg};
   endfunction

   task automatic check_now(input string tag, input logic [7:0] em, input logic [7:0] ea);
      logic [7:0] om, oa;
      om = {lv_m, pr_m, rl_m, lg_m};
      oa = {lv_a, pr_a, rl_a, lg_a};
      tests++;
      assert (om === em && oa === ea) else begin
         fails++;
         $error("FAIL %s: main got %b want %b, al got %b want %b", tag, om, em, oa, ea);
      end
   endtask

   task automatic run(input string tag, input int n, input logic [7:0] em, input logic [7:0] ea);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check_now(tag, em, ea);
      end
   endtask

   initial begin
      tests   = 0;
      fails   = 0;
      reset_n = 1'b0;
      btn     = 2'b00;
      btn_al  = 2'b11;
      #12;
      check_now("reset_state", 8'h00, 8'h00);
      run("reset_hold", 2, 8'h00, 8'h00);
      reset_n = 1'b1;
      run("idle", 4, 8'h00, 8'h00);

      // 1: clean press held 30 cycles
      btn = 2'b01;
      run("s1_sync", 2, 8'h00, 8'h00);
      run("s1_press", 1, v(2'b01, 2'b01, 2'b00, 2'b00), 8'h00);
      run("s1_lock", 15, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      run("s1_long", 1, v(2'b01, 2'b00, 2'b00, 2'b01), 8'h00);
      run("s1_held", 11, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      btn = 2'b00;
      run("s1_relwait", 6, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      run("s1_release", 1, v(2'b00, 2'b00, 2'b01, 2'b00), 8'h00);
      run("s1_quiet", 3, 8'h00, 8'h00);

      // 2: bounce on both edges
      btn = 2'b01;
      run("s2_b1", 1, 8'h00, 8'h00);
      btn = 2'b00;
      run("s2_b2", 1, 8'h00, 8'h00);
      btn = 2'b01;
      run("s2_press", 1, v(2'b01, 2'b01, 2'b00, 2'b00), 8'h00);
      run("s2_lock", 15, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      run("s2_long", 1, v(2'b01, 2'b00, 2'b00, 2'b01), 8'h00);
      run("s2_held", 1, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      btn = 2'b00;
      run("s2_fb1", 1, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      btn = 2'b01;
      run("s2_fb2", 1, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      btn = 2'b00;
      run("s2_fb3", 4, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      run("s2_release", 1, v(2'b00, 2'b00, 2'b01, 2'b00), 8'h00);
      run("s2_quiet", 3, 8'h00, 8'h00);

      // 3: single-cycle tap on channel 1
      btn = 2'b10;
      run("s3_sync1", 1, 8'h00, 8'h00);
      btn = 2'b00;
      run("s3_sync2", 1, 8'h00, 8'h00);
      run("s3_press", 1, v(2'b10, 2'b10, 2'b00, 2'b00), 8'h00);
      run("s3_level", 8, v(2'b10, 2'b00, 2'b00, 2'b00), 8'h00);
      run("s3_release", 1, v(2'b00, 2'b00, 2'b10, 2'b00), 8'h00);
      run("s3_quiet", 3, 8'h00, 8'h00);

      // 4: act drops exactly when the long threshold would be hit
      btn = 2'b01;
      run("s4_sync", 2, 8'h00, 8'h00);
      run("s4_press", 1, v(2'b01, 2'b01, 2'b00, 2'b00), 8'h00);
      run("s4_held", 13, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      btn = 2'b00;
      run("s4_nolong", 6, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      run("s4_release", 1, v(2'b00, 2'b00, 2'b01, 2'b00), 8'h00);
      run("s4_quiet", 3, 8'h00, 8'h00);

      // 5: asynchronous reset while held
      btn = 2'b01;
      run("s5_sync", 2, 8'h00, 8'h00);
      run("s5_press", 1, v(2'b01, 2'b01, 2'b00, 2'b00), 8'h00);
      run("s5_held", 7, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      #3;
      reset_n = 1'b0;
      #1;
      check_now("s5_rst_now", 8'h00, 8'h00);
      run("s5_in_rst", 2, 8'h00, 8'h00);
      reset_n = 1'b1;
      run("s5_resync", 2, 8'h00, 8'h00);
      run("s5_repress", 1, v(2'b01, 2'b01, 2'b00, 2'b00), 8'h00);
      btn = 2'b00;
      run("s5_level", 8, v(2'b01, 2'b00, 2'b00, 2'b00), 8'h00);
      run("s5_release", 1, v(2'b00, 2'b00, 2'b01, 2'b00), 8'h00);
      run("s5_quiet", 3, 8'h00, 8'h00);

      // 6: active-low build, channel 0 pulled low
      btn_al = 2'b10;
      run("s6_sync", 2, 8'h00, 8'h00);
      run("s6_press", 1, 8'h00, v(2'b01, 2'b01, 2'b00, 2'b00));
      run("s6_level", 3, 8'h00, v(2'b01, 2'b00, 2'b00, 2'b00));
      btn_al = 2'b11;
      run("s6_relwait", 6, 8'h00, v(2'b01, 2'b00, 2'b00, 2'b00));
      run("s6_release", 1, 8'h00, v(2'b00, 2'b00, 2'b01, 2'b00));
      run("s6_quiet", 3, 8'h00, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
